mole_game_ctrl: RTL



---
 rtl/mole_game_ctrl_pkg.sv | 25 ++
 rtl/mole_game_ctrl_lfsr.sv | 22 ++
 rtl/mole_game_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/mole_game_ctrl_pkg.sv
// mole_game_ctrl_pkg: shared state encoding, mole lifetimes and LFSR constants
package mole_game_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam int MS_PER_SEC     = 1000;
    localparam int LIFE_MS_EASY   = 1000;
    localparam int LIFE_MS_MEDIUM = 700;
    localparam int LIFE_MS_HARD   = 400;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Feedback bits 7,5,4,3 realise x^8+x^6+x^5+x^4+1
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Level 3 and above fall back to the hard lifetime
    function automatic logic [9:0] life_ms(input int level);
        return (level == 0) ? 10'(LIFE_MS_EASY) :
               (level == 1) ? 10'(LIFE_MS_MEDIUM) : 10'(LIFE_MS_HARD);
    endfunction

endpackage

// File: rtl/mole_game_ctrl_lfsr.sv
// mole_lfsr: free-running 8-bit Fibonacci LFSR supplying mole placement bits
module mole_lfsr
    import mole_game_ctrl_pkg::*;
#(
    parameter int OUT_BITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    output logic [OUT_BITS-1:0] o_rand
);

    logic [7:0] r_lfsr;

    // Shift left every cycle, feeding back the parity of the tapped bits
    always_ff @(posedge clk) begin
        if (rst) r_lfsr <= LFSR_SEED;
        else     r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};
    end

    assign o_rand = r_lfsr[OUT_BITS-1:0];

endmodule

// File: rtl/mole_game_ctrl.sv
// mole_game_ctrl: round FSM, mole placement, lifetime/round timers and scoring
module mole_game_ctrl
    import mole_game_ctrl_pkg::*;
#(
    parameter int MS_CYCLES    = 100000,
    parameter int GAME_SECONDS = 30,
    parameter int MOLE_BITS    = 3,
    parameter int LEVEL_BITS   = 2,
    parameter int SCORE_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_pulse,
    input  logic                    clear_pulse,
    input  logic [LEVEL_BITS-1:0]   difficulty_level,
    input  logic [2**MOLE_BITS-1:0] hit_pulse,
    output logic [2**MOLE_BITS-1:0] mole_onehot,
    output logic [SCORE_WIDTH-1:0]  score,
    output logic [SCORE_WIDTH-1:0]  high_score,
    output logic [7:0]              time_left,
    output logic [1:0]              game_state,
    output logic                    game_over
);

    localparam int NUM_MOLES = 2**MOLE_BITS;
    localparam int PW        = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
    localparam logic [NUM_MOLES-1:0] ONE = NUM_MOLES'(1);

    state_t                 r_state, w_state_nxt;
    logic [PW-1:0]          r_pre;
    logic [9:0]             r_life_ms, r_sec_ms;
    logic [LEVEL_BITS-1:0]  r_level;
    logic [MOLE_BITS-1:0]   r_idx, w_rand, w_new_idx;
    logic [NUM_MOLES-1:0]   r_mole;
    logic [SCORE_WIDTH-1:0] r_score, r_high, w_score_hit, w_score_fin;
    logic [7:0]             r_time;
    logic                   w_play, w_tick, w_hit, w_expire, w_sec, w_end, w_start, w_clear;

    mole_lfsr #(.OUT_BITS(MOLE_BITS)) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .o_rand (w_rand)
    );

    assign w_play      = (r_state == ST_PLAY);
    assign w_tick      = w_play && (r_pre == PW'(MS_CYCLES - 1));
    assign w_hit       = w_play && |(hit_pulse & r_mole);
    assign w_expire    = w_tick && (r_life_ms == life_ms(int'(r_level)) - 10'd1);
    assign w_sec       = w_tick && (r_sec_ms == 10'(MS_PER_SEC - 1));
    assign w_end       = w_sec && (r_time == 8'd1);
    assign w_clear     = !w_play && clear_pulse;
    assign w_start     = !w_play && start_pulse && !clear_pulse;
    assign w_new_idx   = (w_rand == r_idx) ? MOLE_BITS'(r_idx + 1'b1) : w_rand;
    assign w_score_hit = (&r_score) ? r_score : r_score + 1'b1;
    assign w_score_fin = w_hit ? w_score_hit : r_score;

    // Round FSM next state: clear beats start; a round ends when the last second expires
    always_comb begin
        w_state_nxt = r_state;
        if (w_clear)      w_state_nxt = ST_IDLE;
        else if (w_start) w_state_nxt = ST_PLAY;
        else if (w_end)   w_state_nxt = ST_OVER;
    end

    // Round FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Timers, mole placement and scoring
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre     <= '0;
            r_life_ms <= '0;
            r_sec_ms  <= '0;
            r_level   <= '0;
            r_idx     <= '0;
            r_mole    <= '0;
            r_score   <= '0;
            r_high    <= '0;
            r_time    <= '0;
        end else begin
            r_pre     <= (!w_play || w_tick) ? '0 : r_pre + 1'b1;
            r_life_ms <= (!w_play || w_hit || w_expire) ? '0 : (w_tick ? r_life_ms + 1'b1 : r_life_ms);
            r_sec_ms  <= (!w_play || w_sec) ? '0 : (w_tick ? r_sec_ms + 1'b1 : r_sec_ms);
            if (w_start) r_level <= difficulty_level;
            r_time <= w_start ? 8'(GAME_SECONDS) : (w_sec ? r_time - 1'b1 : r_time);
            if (w_start) begin
                r_idx  <= w_rand;
                r_mole <= ONE << w_rand;
            end else if (w_end) begin
                r_mole <= '0;
            end else if (w_hit || w_expire) begin
                r_idx  <= w_new_idx;
                r_mole <= ONE << w_new_idx;
            end
            if (w_clear || w_start) r_score <= '0;
            else if (w_hit)         r_score <= w_score_hit;
            if (w_clear)                              r_high <= '0;
            else if (w_end && (w_score_fin > r_high)) r_high <= w_score_fin;
        end
    end

    assign mole_onehot = r_mole;
    assign score       = r_score;
    assign high_score  = r_high;
    assign time_left   = r_time;
    assign game_state  = r_state;
    assign game_over   = (r_state == ST_OVER);

endmodule
